pkt_drop_fifo: RTL and testbench

Parametrised store-and-forward packet FIFO with cut-through rollback. A packet is written word by word, and the reader sees it only after its last word is committed. Any packet flagged for drop, overflowing, or abandoned mid-write is discarded entirely by rolling back the write pointer. It sits between the input packet parser and the output scheduler and replaces the fixed 72-bit/256-entry FIFO, which had no drop support.

---
 rtl/pkt_drop_fifo_if.sv | 35 +++
 rtl/pkt_drop_fifo.sv | 160 ++++++++++++++++
 tb/tb_pkt_drop_fifo.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/pkt_drop_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : pkt_drop_fifo_if
// Description : Write/read port bundle for the store-and-forward packet FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
interface pkt_drop_fifo_if #(
    parameter int DATA_WIDTH = 72,
    parameter int ADDR_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_wr;
    logic                  in_first;
    logic                  in_last;
    logic                  in_drop;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_last;
    logic                  full;
    logic                  empty;
    logic [ADDR_WIDTH:0]   pkt_count;
    logic [15:0]           drop_count;

    modport master (
        output in_data, in_wr, in_first, in_last, in_drop, rd_en,
        input  out_data, out_valid, out_last, full, empty, pkt_count, drop_count
    );

    modport slave (
        input  in_data, in_wr, in_first, in_last, in_drop, rd_en,
        output out_data, out_valid, out_last, full, empty, pkt_count, drop_count
    );
endinterface
`default_nettype wire

// File: rtl/pkt_drop_fifo.sv
`default_nettype none
// ============================================================================
// Module      : pkt_drop_fifo
// Description : Store-and-forward packet FIFO; packets become readable only
//               once committed, and dropped packets roll the write pointer back.
// Revision    : 1.0 - initial release
// ============================================================================
module pkt_drop_fifo #(
    parameter int DATA_WIDTH = 72,
    parameter int ADDR_WIDTH = 8
) (
    input  wire logic       clk,
    input  wire logic       rst,
    pkt_drop_fifo_if.slave  bus
);
    localparam int C_DEPTH = 1 << ADDR_WIDTH;

    typedef logic [ADDR_WIDTH-1:0] ptr_t;

    logic [DATA_WIDTH:0]   r_mem [C_DEPTH];

    ptr_t                  r_wr_ptr_q,     w_wr_ptr_d;
    ptr_t                  r_commit_ptr_q, w_commit_ptr_d;
    ptr_t                  r_rd_ptr_q,     w_rd_ptr_d;
    logic                  r_open_q,       w_open_d;
    logic                  r_ovf_q,        w_ovf_d;
    logic [ADDR_WIDTH:0]   r_pkt_count_q,  w_pkt_count_d;
    logic [15:0]           r_drop_count_q, w_drop_count_d;
    logic                  r_out_valid_q,  w_out_valid_d;
    logic                  r_out_last_q,   w_out_last_d;
    logic [DATA_WIDTH-1:0] r_out_data_q,   w_out_data_d;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_rd_acc;
    logic                  w_rd_last;
    logic                  w_wr_live;
    logic                  w_restart;
    ptr_t                  w_base;
    ptr_t                  w_base_inc;
    logic                  w_room;
    logic                  w_ovf_eff;
    logic                  w_commit;
    logic [1:0]            w_drop_inc;
    logic [16:0]           w_drop_sum;
    logic                  w_mem_we;
    ptr_t                  w_mem_waddr;

    assign w_full    = (r_wr_ptr_q + ptr_t'(1)) == r_rd_ptr_q;
    assign w_empty   = r_rd_ptr_q == r_commit_ptr_q;
    assign w_rd_acc  = bus.rd_en && !w_empty;
    assign w_rd_last = r_mem[r_rd_ptr_q][DATA_WIDTH];

    // A first word while a packet is open restarts at commit_ptr after discarding the old one
    assign w_wr_live  = bus.in_wr && (r_open_q || bus.in_first);
    assign w_restart  = bus.in_wr && bus.in_first && r_open_q;
    assign w_base     = w_restart ? r_commit_ptr_q : r_wr_ptr_q;
    assign w_base_inc = w_base + ptr_t'(1);
    assign w_room     = w_base_inc != r_rd_ptr_q;

    always_comb begin
        w_wr_ptr_d     = r_wr_ptr_q;
        w_commit_ptr_d = r_commit_ptr_q;
        w_open_d       = r_open_q;
        w_ovf_d        = r_ovf_q;
        w_ovf_eff      = 1'b0;
        w_commit       = 1'b0;
        w_drop_inc     = 2'd0;
        w_mem_we       = 1'b0;
        w_mem_waddr    = w_base;

        if (bus.in_drop && (r_open_q || w_wr_live)) begin
            w_wr_ptr_d = r_commit_ptr_q;
            w_open_d   = 1'b0;
            w_ovf_d    = 1'b0;
            w_drop_inc = 2'd1;
        end else if (w_wr_live) begin
            w_drop_inc = {1'b0, w_restart};
            w_ovf_eff  = (bus.in_first ? 1'b0 : r_ovf_q) | !w_room;
            w_mem_we   = w_room;
            if (bus.in_last) begin
                w_open_d = 1'b0;
                w_ovf_d  = 1'b0;
                if (w_ovf_eff) begin
                    w_wr_ptr_d = r_commit_ptr_q;
                    w_drop_inc = w_drop_inc + 2'd1;
                end else begin
                    w_wr_ptr_d     = w_base_inc;
                    w_commit_ptr_d = w_base_inc;
                    w_commit       = 1'b1;
                end
            end else begin
                w_wr_ptr_d = w_room ? w_base_inc : w_base;
                w_open_d   = 1'b1;
                w_ovf_d    = w_ovf_eff;
            end
        end
    end

    always_comb begin
        w_rd_ptr_d    = r_rd_ptr_q;
        w_out_valid_d = w_rd_acc;
        w_out_data_d  = r_out_data_q;
        w_out_last_d  = r_out_last_q;
        if (w_rd_acc) begin
            w_rd_ptr_d   = r_rd_ptr_q + ptr_t'(1);
            w_out_data_d = r_mem[r_rd_ptr_q][DATA_WIDTH-1:0];
            w_out_last_d = w_rd_last;
        end
    end

    always_comb begin
        w_pkt_count_d = r_pkt_count_q
                      + {{ADDR_WIDTH{1'b0}}, w_commit}
                      - {{ADDR_WIDTH{1'b0}}, (w_rd_acc && w_rd_last)};
        w_drop_sum     = {1'b0, r_drop_count_q} + {15'd0, w_drop_inc};
        w_drop_count_d = w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_waddr] <= {bus.in_last, bus.in_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr_q     <= '0;
            r_commit_ptr_q <= '0;
            r_rd_ptr_q     <= '0;
            r_open_q       <= 1'b0;
            r_ovf_q        <= 1'b0;
            r_pkt_count_q  <= '0;
            r_drop_count_q <= '0;
            r_out_valid_q  <= 1'b0;
            r_out_last_q   <= 1'b0;
            r_out_data_q   <= '0;
        end else begin
            r_wr_ptr_q     <= w_wr_ptr_d;
            r_commit_ptr_q <= w_commit_ptr_d;
            r_rd_ptr_q     <= w_rd_ptr_d;
            r_open_q       <= w_open_d;
            r_ovf_q        <= w_ovf_d;
            r_pkt_count_q  <= w_pkt_count_d;
            r_drop_count_q <= w_drop_count_d;
            r_out_valid_q  <= w_out_valid_d;
            r_out_last_q   <= w_out_last_d;
            r_out_data_q   <= w_out_data_d;
        end
    end

    assign bus.out_data   = r_out_data_q;
    assign bus.out_valid  = r_out_valid_q;
    assign bus.out_last   = r_out_last_q;
    assign bus.full       = w_full;
    assign bus.empty      = w_empty;
    assign bus.pkt_count  = r_pkt_count_q;
    assign bus.drop_count = r_drop_count_q;
endmodule
`default_nettype wire

// File: tb/tb_pkt_drop_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_pkt_drop_fifo
// Description : Directed self-checking bench for pkt_drop_fifo (depth 8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pkt_drop_fifo;
    localparam int DW = 16;
    localparam int AW = 3;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_mis;

    pkt_drop_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    pkt_drop_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.in_wr    = 1'b0;
        bus.in_first = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_drop  = 1'b0;
        bus.rd_en    = 1'b0;
    endtask

    task automatic wr(input logic [DW-1:0] d, input logic f, input logic l, input logic drp);
        bus.in_data  = d;
        bus.in_wr    = 1'b1;
        bus.in_first = f;
        bus.in_last  = l;
        bus.in_drop  = drp;
        step();
        idle_inputs();
    endtask

    task automatic rd();
        bus.rd_en = 1'b1;
        step();
        bus.rd_en = 1'b0;
    endtask

    task automatic chk_word(input string tag, input logic [DW-1:0] d, input logic l);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_data"},  32'(bus.out_data),  32'(d));
        chk({tag, "_last"},  32'(bus.out_last),  32'(l));
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        bus.in_data = '0;
        idle_inputs();

        // Reset state
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst_valid", 32'(bus.out_valid),  32'd0);
        chk("rst_data",  32'(bus.out_data),   32'd0);
        chk("rst_last",  32'(bus.out_last),   32'd0);
        chk("rst_pkt",   32'(bus.pkt_count),  32'd0);
        chk("rst_drop",  32'(bus.drop_count), 32'd0);
        chk("rst_full",  32'(bus.full),       32'd0);
        chk("rst_empty", 32'(bus.empty),      32'd1);

        // 3-word packet, invisible until its last word commits
        wr(16'hA001, 1'b1, 1'b0, 1'b0);
        wr(16'hA002, 1'b0, 1'b0, 1'b0);
        chk("a_uncommitted_empty", 32'(bus.empty), 32'd1);
        wr(16'hA003, 1'b0, 1'b1, 1'b0);
        chk("a_commit_empty", 32'(bus.empty),     32'd0);
        chk("a_commit_pkt",   32'(bus.pkt_count), 32'd1);
        rd();
        chk_word("a1", 16'hA001, 1'b0);
        chk("a1_pkt", 32'(bus.pkt_count), 32'd1);
        rd();
        chk_word("a2", 16'hA002, 1'b0);
        rd();
        chk_word("a3", 16'hA003, 1'b1);
        chk("a_end_pkt",   32'(bus.pkt_count), 32'd0);
        chk("a_end_empty", 32'(bus.empty),     32'd1);
        step();
        chk("a_idle_valid", 32'(bus.out_valid), 32'd0);

        // in_drop on the 3rd word; 4th word has no open packet and is ignored
        wr(16'hD001, 1'b1, 1'b0, 1'b0);
        wr(16'hD002, 1'b0, 1'b0, 1'b0);
        wr(16'hD003, 1'b0, 1'b0, 1'b1);
        wr(16'hD004, 1'b0, 1'b0, 1'b0);
        chk("d_drop_count", 32'(bus.drop_count), 32'd1);
        chk("d_empty",      32'(bus.empty),      32'd1);
        wr(16'hB001, 1'b1, 1'b0, 1'b0);
        wr(16'hB002, 1'b0, 1'b1, 1'b0);
        chk("b_pkt", 32'(bus.pkt_count), 32'd1);
        rd();
        chk_word("b1", 16'hB001, 1'b0);
        rd();
        chk_word("b2", 16'hB002, 1'b1);
        chk("b_empty", 32'(bus.empty), 32'd1);

        // 9-word packet into a 7-entry FIFO overflows and is dropped
        for (int i = 0; i < 6; i++) wr(16'hC000 + 16'(i), (i == 0), 1'b0, 1'b0);
        chk("ovf_full_at6", 32'(bus.full), 32'd0);
        wr(16'hC006, 1'b0, 1'b0, 1'b0);
        chk("ovf_full_at7", 32'(bus.full), 32'd1);
        wr(16'hC007, 1'b0, 1'b0, 1'b0);
        chk("ovf_full_at8", 32'(bus.full), 32'd1);
        wr(16'hC008, 1'b0, 1'b1, 1'b0);
        chk("ovf_drop_count", 32'(bus.drop_count), 32'd2);
        chk("ovf_empty",      32'(bus.empty),      32'd1);
        chk("ovf_full_freed", 32'(bus.full),       32'd0);
        chk("ovf_pkt",        32'(bus.pkt_count),  32'd0);
        wr(16'hE001, 1'b1, 1'b0, 1'b0);
        wr(16'hE002, 1'b0, 1'b1, 1'b0);
        rd();
        chk_word("e1", 16'hE001, 1'b0);
        rd();
        chk_word("e2", 16'hE002, 1'b1);

        // New first word mid-packet discards the open packet
        wr(16'h5D01, 1'b1, 1'b0, 1'b0);
        wr(16'h5D02, 1'b0, 1'b0, 1'b0);
        wr(16'h5C01, 1'b1, 1'b0, 1'b0);
        chk("restart_drop_count", 32'(bus.drop_count), 32'd3);
        chk("restart_empty",      32'(bus.empty),      32'd1);
        wr(16'h5C02, 1'b0, 1'b1, 1'b0);
        chk("c_pkt", 32'(bus.pkt_count), 32'd1);
        rd();
        chk_word("c1", 16'h5C01, 1'b0);
        rd();
        chk_word("c2", 16'h5C02, 1'b1);
        chk("c_empty", 32'(bus.empty), 32'd1);

        // 20 single-word packets across the pointer wrap, read while writing
        wr(16'h0100, 1'b1, 1'b1, 1'b0);
        chk("wrap_pkt0", 32'(bus.pkt_count), 32'd1);
        for (int i = 1; i < 20; i++) begin
            bus.in_data  = 16'h0100 + 16'(i);
            bus.in_wr    = 1'b1;
            bus.in_first = 1'b1;
            bus.in_last  = 1'b1;
            bus.rd_en    = 1'b1;
            step();
            chk("wrap_data",  32'(bus.out_data),  32'h0100 + 32'(i - 1));
            chk("wrap_valid", 32'(bus.out_valid), 32'd1);
            chk("wrap_pkt",   32'(bus.pkt_count), 32'd1);
        end
        idle_inputs();
        rd();
        chk_word("wrap_tail", 16'h0113, 1'b1);
        chk("wrap_end_pkt", 32'(bus.pkt_count), 32'd0);

        // rd_en with only an uncommitted packet present
        bus.rd_en = 1'b1;
        wr(16'hF001, 1'b1, 1'b0, 1'b0);
        bus.rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("open_rd_valid", 32'(bus.out_valid), 32'd0);
            chk("open_rd_hold",  32'(bus.out_data),  32'h0113);
        end
        bus.rd_en = 1'b0;

        // Reset in the middle of a write
        bus.in_data = 16'hF002;
        bus.in_wr   = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle_inputs();
        chk("mrst_valid", 32'(bus.out_valid),  32'd0);
        chk("mrst_data",  32'(bus.out_data),   32'd0);
        chk("mrst_last",  32'(bus.out_last),   32'd0);
        chk("mrst_pkt",   32'(bus.pkt_count),  32'd0);
        chk("mrst_drop",  32'(bus.drop_count), 32'd0);
        chk("mrst_full",  32'(bus.full),       32'd0);
        chk("mrst_empty", 32'(bus.empty),      32'd1);
        wr(16'h7777, 1'b1, 1'b1, 1'b0);
        rd();
        chk_word("post_rst", 16'h7777, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
`default_nettype wire
